// File: rtl/an_encoder_n29.sv
// Serial AN-code encoder: out_code = in_msg * A, computed by shift-add over AW cycles.
// Latency: accept at edge t0 -> out_valid high after edge t0+AW; one message in flight.
// Backpressure: in_ready only in IDLE; codeword held in DONE until out_ready, stall unbounded.
// Optional macro AN_ENC_ERR_INJ_EN adds err_inj/err_pos to flip one codeword bit for decoder tests.
module an_encoder_n29 #(
    parameter int A  = 29,
    parameter int AW = 5,
    parameter int MW = 10,
    parameter int CW = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MW-1:0]          in_msg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW-1:0]          out_code,
    output logic                   busy
`ifdef AN_ENC_ERR_INJ_EN
    ,
    input  logic                   err_inj,
    input  logic [$clog2(CW)-1:0]  err_pos
`endif
);

    localparam int CNTW = $clog2(AW);
    localparam logic [AW-1:0] A_BITS = AW'(A);
    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(AW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [MW-1:0]     msg_q;
    logic [CW-1:0]     acc_q;
    logic [CNTW-1:0]   cnt_q;
    logic [CW-1:0]     code_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    logic [CW-1:0]     partial_d;
    logic [CW-1:0]     acc_d;
    logic [CW-1:0]     flip_d;

`ifdef AN_ENC_ERR_INJ_EN
    logic                   err_inj_q;
    logic [$clog2(CW)-1:0]  err_pos_q;
`endif

    // Partial product for the current multiplier bit, next accumulator value and optional error mask
    always_comb begin
        partial_d = '0;
        if (A_BITS[cnt_q]) begin
            partial_d = CW'(msg_q) << cnt_q;
        end
        acc_d  = acc_q + partial_d;
        flip_d = '0;
`ifdef AN_ENC_ERR_INJ_EN
        // Positions beyond the codeword width select no bit at all
        if (err_inj_q && (int'(err_pos_q) < CW)) begin
            flip_d = CW'(1) << err_pos_q;
        end
`endif
    end

    // Control FSM and datapath; all outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            msg_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            code_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef AN_ENC_ERR_INJ_EN
            err_inj_q   <= 1'b0;
            err_pos_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        msg_q      <= in_msg;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_MUL;
`ifdef AN_ENC_ERR_INJ_EN
                        err_inj_q  <= err_inj;
                        err_pos_q  <= err_pos;
`endif
                    end
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == LAST_STEP) begin
                        code_q      <= acc_d ^ flip_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // code_q is left untouched so the last codeword stays visible after transfer
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_code  = code_q;
    assign busy      = busy_q;

endmodule
